// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic sequencer: order codes, FSM states
// and the default datapath width.
package arith_pkg;

  localparam int OP_ILLEGAL_MIN = 6;
  localparam int DEFAULT_WIDTH  = 30;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_IO  = 3'd5
  } op_e;

  typedef enum logic [4:0] {
    IDLE,
    ADD,
    SUB_NOT,
    SUB_CHK,
    SUB_SUM,
    MUL_INIT,
    MUL_ADD,
    MUL_SHR,
    DIV_INIT,
    DIV_CHK,
    DIV_SHL,
    DIV_STEP,
    AND_OP,
    IO_SHL,
    DONE_B2C,
    DONE_C2B,
    IO_DONE
  } state_e;

endpackage

// File: rtl/arith_iter_cnt.sv
// Loop counter for the iterative orders; wraps to zero on the step that
// reaches the limit, so it always reads zero once a loop has exited.
module arith_iter_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] cnt;

  assign last = (cnt == limit);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/arith_seq.sv
// Arithmetic order sequencer: decodes orders, steps the datapath micro-ops
// for add/sub/mul/div/and/io and maintains the three sign registers.
module arith_seq
  import arith_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int IO_MAX = 8,
  localparam int IO_W   = $clog2(IO_MAX + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            order_valid,
  input  logic [2:0]      order_op,
  input  logic [IO_W-1:0] io_shift_n,
  input  logic            abort,
  input  logic            ctrl_abs,
  input  logic            carry_out,
  input  logic            reg_c_lsb,
  input  logic            reg_c_msb,
  input  logic            reg_b0,
  input  logic            mv_c_to_a,
  input  logic            mv_c_to_b,
  input  logic            mv_b_to_c,
  input  logic            sign_load_c,
  input  logic            sign_in,
  output logic            busy,
  output logic            answer,
  output logic            answer_io,
  output logic            overflow,
  output logic            order_err,
  output logic            do_not_a,
  output logic            do_not_b,
  output logic            do_sum,
  output logic            do_and,
  output logic            do_clear_b,
  output logic            do_set_c_lsb,
  output logic            do_shl_b,
  output logic            do_shl_c,
  output logic            do_shr_bc,
  output logic            do_move_b_to_c,
  output logic            do_move_c_to_b,
  output logic            a_sign,
  output logic            b_sign,
  output logic            c_sign
);

  // The counter also walks the IO shift count, so it must hold IO_MAX too.
  localparam int CNT_W = ($clog2(WIDTH) > IO_W) ? $clog2(WIDTH) : IO_W;
  localparam logic [2:0] OP_ILL = 3'(OP_ILLEGAL_MIN);

  state_e           state, state_nxt;
  op_e              op;
  logic             cnt_inc, cnt_clear, cnt_last;
  logic [CNT_W-1:0] cnt_limit, io_limit, io_clamped;
  logic             io_load;
  logic             fsm_b_upd, fsm_b_val;

  assign op         = op_e'(order_op);
  assign busy       = resetn && (state != IDLE);
  assign io_clamped = (io_shift_n > IO_W'(IO_MAX)) ? CNT_W'(IO_MAX) : CNT_W'(io_shift_n);
  assign cnt_limit  = (state == IO_SHL) ? io_limit : CNT_W'(WIDTH - 1);
  assign cnt_clear  = abort || (state == IDLE);

  arith_iter_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .limit  (cnt_limit),
    .last   (cnt_last)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt      = state;
    answer         = 1'b0;
    answer_io      = 1'b0;
    overflow       = 1'b0;
    order_err      = 1'b0;
    do_not_a       = 1'b0;
    do_not_b       = 1'b0;
    do_sum         = 1'b0;
    do_and         = 1'b0;
    do_clear_b     = 1'b0;
    do_set_c_lsb   = 1'b0;
    do_shl_b       = 1'b0;
    do_shl_c       = 1'b0;
    do_shr_bc      = 1'b0;
    do_move_b_to_c = 1'b0;
    do_move_c_to_b = 1'b0;
    cnt_inc        = 1'b0;
    io_load        = 1'b0;
    fsm_b_upd      = 1'b0;
    fsm_b_val      = 1'b0;

    // Reset silences everything; abort kills the order and drops any new one.
    if (resetn && abort) begin
      state_nxt = IDLE;
    end else if (resetn) begin
      if (order_valid && state != IDLE) order_err = 1'b1;
      case (state)
        IDLE: begin
          if (order_valid) begin
            if (order_op >= OP_ILL) begin
              order_err = 1'b1;
            end else begin
              case (op)
                OP_ADD:  state_nxt = ADD;
                OP_SUB:  state_nxt = SUB_NOT;
                OP_MUL:  state_nxt = MUL_INIT;
                OP_DIV:  state_nxt = DIV_INIT;
                OP_AND:  state_nxt = AND_OP;
                OP_IO: begin
                  io_load   = 1'b1;
                  state_nxt = (io_clamped == '0) ? IO_DONE : IO_SHL;
                end
                default: state_nxt = IDLE;
              endcase
            end
          end
        end
        ADD: begin
          if (carry_out) begin
            overflow  = 1'b1;
            state_nxt = IDLE;
          end else begin
            do_sum    = 1'b1;
            state_nxt = DONE_B2C;
          end
        end
        SUB_NOT: begin
          do_not_a  = 1'b1;
          state_nxt = SUB_CHK;
        end
        SUB_CHK: begin
          fsm_b_upd = 1'b1;
          fsm_b_val = b_sign & ~carry_out;
          if (carry_out) begin
            do_sum    = 1'b1;
            state_nxt = DONE_B2C;
          end else begin
            do_not_a  = 1'b1;
            do_not_b  = 1'b1;
            state_nxt = SUB_SUM;
          end
        end
        SUB_SUM: begin
          do_sum    = 1'b1;
          state_nxt = DONE_B2C;
        end
        MUL_INIT: begin
          do_clear_b = 1'b1;
          fsm_b_upd  = 1'b1;
          fsm_b_val  = a_sign ^ b_sign;
          state_nxt  = MUL_ADD;
        end
        MUL_ADD: begin
          do_sum    = reg_c_lsb;
          state_nxt = MUL_SHR;
        end
        MUL_SHR: begin
          do_shr_bc = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = cnt_last ? DONE_B2C : MUL_ADD;
        end
        DIV_INIT: begin
          do_not_a  = 1'b1;
          fsm_b_upd = 1'b1;
          fsm_b_val = a_sign ^ b_sign;
          state_nxt = DIV_CHK;
        end
        DIV_CHK: begin
          if (carry_out) begin
            overflow  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DIV_SHL;
          end
        end
        DIV_SHL: begin
          do_shl_b  = 1'b1;
          do_shl_c  = 1'b1;
          state_nxt = DIV_STEP;
        end
        DIV_STEP: begin
          do_sum       = (carry_out != reg_b0);
          do_set_c_lsb = (carry_out != reg_b0);
          cnt_inc      = 1'b1;
          state_nxt    = cnt_last ? DONE_C2B : DIV_SHL;
        end
        AND_OP: begin
          do_and    = 1'b1;
          state_nxt = DONE_C2B;
        end
        IO_SHL: begin
          do_shl_c  = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = cnt_last ? IO_DONE : IO_SHL;
        end
        DONE_B2C: begin
          do_move_b_to_c = 1'b1;
          answer         = 1'b1;
          state_nxt      = IDLE;
        end
        DONE_C2B: begin
          do_move_c_to_b = 1'b1;
          fsm_b_upd      = 1'b1;
          fsm_b_val      = c_sign;
          answer         = 1'b1;
          state_nxt      = IDLE;
        end
        IO_DONE: begin
          answer_io = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: io_limit needs no reset; it is always written on IO accept before IO_SHL reads it.
  always_ff @(posedge clk) begin
    if (io_load) io_limit <= io_clamped - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      c_sign <= 1'b0;
    end else begin
      if (mv_c_to_a)  a_sign <= c_sign & ~ctrl_abs;
      else if (abort) a_sign <= 1'b0;

      if (mv_c_to_b)       b_sign <= c_sign & ~ctrl_abs;
      else if (mv_b_to_c)  b_sign <= b_sign & ~ctrl_abs;
      else if (fsm_b_upd)  b_sign <= fsm_b_val;
      else if (do_clear_b) b_sign <= 1'b0;

      if (mv_b_to_c)           c_sign <= b_sign & ~ctrl_abs;
      else if (do_move_b_to_c) c_sign <= b_sign;
      else if (do_shl_c)       c_sign <= reg_c_msb;
      else if (sign_load_c)    c_sign <= sign_in;
    end
  end

endmodule

// File: tb/tb_arith_seq.sv
// Self-checking bench for arith_seq: expected completion/error pulses are
// queued with their cycle when an order is driven and matched as they appear.
module tb_arith_seq;
  import arith_pkg::*;

  localparam int WIDTH  = 30;
  localparam int IO_MAX = 8;
  localparam int IO_W   = $clog2(IO_MAX + 1);

  logic clk = 1'b0, resetn = 1'b0, order_valid = 1'b0, abort = 1'b0, ctrl_abs = 1'b0;
  logic carry_out = 1'b0, reg_c_lsb = 1'b0, reg_c_msb = 1'b0, reg_b0 = 1'b0;
  logic mv_c_to_a = 1'b0, mv_c_to_b = 1'b0, mv_b_to_c = 1'b0, sign_load_c = 1'b0, sign_in = 1'b0;
  logic [2:0]      order_op = 3'd0;
  logic [IO_W-1:0] io_shift_n = '0;
  logic busy, answer, answer_io, overflow, order_err;
  logic do_not_a, do_not_b, do_sum, do_and, do_clear_b, do_set_c_lsb;
  logic do_shl_b, do_shl_c, do_shr_bc, do_move_b_to_c, do_move_c_to_b;
  logic a_sign, b_sign, c_sign;

  arith_seq #(.WIDTH(WIDTH), .IO_MAX(IO_MAX)) dut (
    .clk(clk), .resetn(resetn), .order_valid(order_valid), .order_op(order_op),
    .io_shift_n(io_shift_n), .abort(abort), .ctrl_abs(ctrl_abs), .carry_out(carry_out),
    .reg_c_lsb(reg_c_lsb), .reg_c_msb(reg_c_msb), .reg_b0(reg_b0),
    .mv_c_to_a(mv_c_to_a), .mv_c_to_b(mv_c_to_b), .mv_b_to_c(mv_b_to_c),
    .sign_load_c(sign_load_c), .sign_in(sign_in), .busy(busy), .answer(answer),
    .answer_io(answer_io), .overflow(overflow), .order_err(order_err),
    .do_not_a(do_not_a), .do_not_b(do_not_b), .do_sum(do_sum), .do_and(do_and),
    .do_clear_b(do_clear_b), .do_set_c_lsb(do_set_c_lsb), .do_shl_b(do_shl_b),
    .do_shl_c(do_shl_c), .do_shr_bc(do_shr_bc), .do_move_b_to_c(do_move_b_to_c),
    .do_move_c_to_b(do_move_c_to_b), .a_sign(a_sign), .b_sign(b_sign), .c_sign(c_sign)
  );

  always #5 clk = ~clk;

  typedef enum {EV_ANSWER, EV_ANSWER_IO, EV_OVERFLOW, EV_ERR} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  tests_run = 0;
  int  tests_failed = 0;
  int  n_sum = 0, n_shr = 0, n_shl_b = 0, n_shl_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every completion/error pulse must match the oldest expectation.
  task automatic observe(input ev_e kind);
    ev_t exp_ev;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none", kind.name(), cyc);
    end else begin
      exp_ev = sb.pop_front();
      if (exp_ev.kind != kind || exp_ev.cyc != cyc) begin
        tests_failed++;
        $display("FAIL event_match: got %s at cycle %0d, required %s at cycle %0d",
                 kind.name(), cyc, exp_ev.kind.name(), exp_ev.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (answer)    observe(EV_ANSWER);
    if (answer_io) observe(EV_ANSWER_IO);
    if (overflow)  observe(EV_OVERFLOW);
    if (order_err) observe(EV_ERR);
    if (do_sum)    n_sum++;
    if (do_shr_bc) n_shr++;
    if (do_shl_b)  n_shl_b++;
    if (do_shl_c)  n_shl_c++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_sum = 0; n_shr = 0; n_shl_b = 0; n_shl_c = 0;
  endtask

  task automatic expect_ev(input ev_e kind, input int at);
    ev_t e;
    int  pos;
    e.kind = kind;
    e.cyc  = at;
    pos    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  // Called just after a rising edge; holds order_valid for exactly one cycle.
  task automatic issue(input logic [2:0] op, input int n);
    order_op    = op;
    io_shift_n  = IO_W'(n);
    order_valid = 1'b1;
    tick();
    order_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    order_valid = 1'b1;
    abort       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b, required 0", busy);
    end
    tests_run++;
    if ({answer, answer_io, overflow, order_err, do_not_a, do_not_b, do_sum, do_and,
         do_clear_b, do_set_c_lsb, do_shl_b, do_shl_c, do_shr_bc, do_move_b_to_c,
         do_move_c_to_b} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_pulses: got nonzero pulse outputs, required all 0");
    end
    tests_run++;
    if ({a_sign, b_sign, c_sign} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_signs: got %b, required 000", {a_sign, b_sign, c_sign});
    end
    tick();
    order_valid = 1'b0;
    abort       = 1'b0;
    resetn      = 1'b1;
    tick();
  endtask

  task automatic test_add();
    clear_counts();
    carry_out = 1'b0;
    expect_ev(EV_ANSWER, cyc + 2);
    issue(OP_ADD, 0);
    drain("add", 10);
    tests_run++;
    if (n_sum != 1) begin
      tests_failed++;
      $display("FAIL add_sum_count: got %0d, required 1", n_sum);
    end
    tick();
    clear_counts();
    carry_out = 1'b1;
    expect_ev(EV_OVERFLOW, cyc + 1);
    issue(OP_ADD, 0);
    drain("add_ovf", 10);
    repeat (3) @(negedge clk);
    tests_run++;
    if (n_sum != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_ovf_idle: got sums=%0d busy=%b, required sums=0 busy=0", n_sum, busy);
    end
    carry_out = 1'b0;
    tick();
  endtask

  task automatic test_sub();
    sign_in     = 1'b1;
    sign_load_c = 1'b1;
    tick();
    sign_load_c = 1'b0;
    mv_c_to_b   = 1'b1;
    tick();
    mv_c_to_b   = 1'b0;
    tests_run++;
    if ({b_sign, c_sign} !== 2'b11) begin
      tests_failed++;
      $display("FAIL sub_setup_signs: got b=%b c=%b, required b=1 c=1", b_sign, c_sign);
    end
    // carry=0 at SUB_CHK: b_sign & !0 keeps b_sign, extra SUB_SUM cycle.
    clear_counts();
    carry_out = 1'b0;
    expect_ev(EV_ANSWER, cyc + 4);
    issue(OP_SUB, 0);
    drain("sub_c0", 10);
    tick();
    tests_run++;
    if ({b_sign, c_sign} !== 2'b11 || n_sum != 1) begin
      tests_failed++;
      $display("FAIL sub_c0_result: got b=%b c=%b sums=%0d, required b=1 c=1 sums=1",
               b_sign, c_sign, n_sum);
    end
    // carry=1 at SUB_CHK: sign cleared and result moved one cycle earlier.
    clear_counts();
    carry_out = 1'b1;
    expect_ev(EV_ANSWER, cyc + 3);
    issue(OP_SUB, 0);
    drain("sub_c1", 10);
    tick();
    tests_run++;
    if ({b_sign, c_sign} !== 2'b00 || n_sum != 1) begin
      tests_failed++;
      $display("FAIL sub_c1_result: got b=%b c=%b sums=%0d, required b=0 c=0 sums=1",
               b_sign, c_sign, n_sum);
    end
    carry_out = 1'b0;
  endtask

  task automatic test_mul();
    for (int lsb = 1; lsb >= 0; lsb--) begin
      clear_counts();
      reg_c_lsb = lsb[0];
      expect_ev(EV_ANSWER, cyc + 62);
      issue(OP_MUL, 0);
      drain("mul", 100);
      @(negedge clk);
      #1;
      tests_run++;
      if (n_sum != 30 * lsb || n_shr != WIDTH || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL mul_lsb%0d: got sums=%0d shr=%0d busy=%b, required sums=%0d shr=%0d busy=0",
                 lsb, n_sum, n_shr, busy, 30 * lsb, WIDTH);
      end
      tick();
    end
    reg_c_lsb = 1'b0;
  endtask

  task automatic test_div();
    clear_counts();
    carry_out = 1'b0;
    reg_b0    = 1'b1;
    reg_c_msb = 1'b1;
    expect_ev(EV_ANSWER, cyc + 63);
    issue(OP_DIV, 0);
    drain("div", 100);
    tick();
    tests_run++;
    if (n_shl_b != WIDTH || n_shl_c != WIDTH || n_sum != WIDTH) begin
      tests_failed++;
      $display("FAIL div_counts: got shl_b=%0d shl_c=%0d sums=%0d, required %0d each",
               n_shl_b, n_shl_c, n_sum, WIDTH);
    end
    tests_run++;
    if ({b_sign, c_sign} !== 2'b11) begin
      tests_failed++;
      $display("FAIL div_signs: got b=%b c=%b, required b=1 c=1", b_sign, c_sign);
    end
    clear_counts();
    carry_out = 1'b1;
    expect_ev(EV_OVERFLOW, cyc + 2);
    issue(OP_DIV, 0);
    drain("div_ovf", 10);
    repeat (3) @(negedge clk);
    tests_run++;
    if (n_shl_b != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_ovf: got shl_b=%0d busy=%b, required shl_b=0 busy=0", n_shl_b, busy);
    end
    carry_out = 1'b0;
    reg_b0    = 1'b0;
    reg_c_msb = 1'b0;
    tick();
  endtask

  task automatic test_io();
    int n_tab[3]   = '{4, 0, 15};
    int shift_exp;
    for (int i = 0; i < 3; i++) begin
      shift_exp = (n_tab[i] > IO_MAX) ? IO_MAX : n_tab[i];
      clear_counts();
      expect_ev(EV_ANSWER_IO, cyc + shift_exp + 1);
      issue(OP_IO, n_tab[i]);
      drain("io", 40);
      tests_run++;
      if (n_shl_c != shift_exp) begin
        tests_failed++;
        $display("FAIL io_n%0d_shifts: got %0d, required %0d", n_tab[i], n_shl_c, shift_exp);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int acc;
    sign_in     = 1'b1;
    sign_load_c = 1'b1;
    tick();
    sign_load_c = 1'b0;
    ctrl_abs    = 1'b1;
    mv_c_to_a   = 1'b1;
    tick();
    tests_run++;
    if (a_sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL abs_move_a: got %b, required 0", a_sign);
    end
    ctrl_abs = 1'b0;
    tick();
    mv_c_to_a = 1'b0;
    tests_run++;
    if (a_sign !== 1'b1) begin
      tests_failed++;
      $display("FAIL move_a: got %b, required 1", a_sign);
    end
    reg_c_lsb = 1'b1;
    acc = cyc;
    issue(OP_MUL, 0);
    while (cyc < acc + 20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || a_sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_mul: got busy=%b a_sign=%b, required busy=0 a_sign=0", busy, a_sign);
    end
    expect_ev(EV_ANSWER, cyc + 2);
    issue(OP_ADD, 0);
    drain("abort_add", 10);
    tick();
    // A full-length MUL after the abort proves the counter was left at zero.
    clear_counts();
    expect_ev(EV_ANSWER, cyc + 62);
    issue(OP_MUL, 0);
    drain("abort_mul_again", 100);
    tests_run++;
    if (n_sum != WIDTH) begin
      tests_failed++;
      $display("FAIL abort_mul_again_sums: got %0d, required %0d", n_sum, WIDTH);
    end
    tick();
    order_op    = OP_ADD;
    order_valid = 1'b1;
    abort       = 1'b1;
    tick();
    order_valid = 1'b0;
    abort       = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_drops_order: got busy=%b, required 0", busy);
    end
    repeat (3) @(negedge clk);
    reg_c_lsb = 1'b0;
    tick();
  endtask

  task automatic test_errors();
    int acc;
    for (int op = 6; op <= 7; op++) begin
      expect_ev(EV_ERR, cyc);
      issue(3'(op), 0);
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_op%0d: got busy=%b, required 0", op, busy);
      end
      drain("illegal_op", 5);
      tick();
    end
    acc = cyc;
    expect_ev(EV_ANSWER, acc + 62);
    issue(OP_MUL, 0);
    while (cyc < acc + 5) tick();
    expect_ev(EV_ERR, cyc);
    order_op    = OP_ADD;
    order_valid = 1'b1;
    tick();
    order_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_order_ignored: got busy=%b, required 1", busy);
    end
    drain("busy_order", 100);
    tick();
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = cyc;
    expect_ev(EV_ANSWER, acc + 2);
    expect_ev(EV_ANSWER, acc + 5);
    expect_ev(EV_ANSWER_IO, acc + 9);
    issue(OP_ADD, 0);
    tick();
    tick();
    issue(OP_AND, 0);
    tick();
    tick();
    issue(OP_IO, 2);
    drain("back_to_back", 20);
    @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_back_idle: got busy=%b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_io();
    test_abort();
    test_errors();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
